// File: rtl/satsub_pipe.sv
// Two-stage saturating/wrapping subtractor (a - b); optional sticky flag under SATSUB_STICKY_EN.
// Latency: result offered two cycles after the input beat is accepted; one beat per cycle sustained.
// Backpressure: stages stall on out_ready low; in_ready = S1 empty or S1 advancing (no in_valid path).
module satsub_pipe #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             sat
`ifdef SATSUB_STICKY_EN
    ,
    input  logic             sat_clr,
    output logic             sat_sticky
`endif
);

    logic             s1_vld;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [1:0]       s1_mode;

    logic             s2_adv;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nxt_y;
    logic             nxt_sat;

    // S1 always moves with S2, so a full pipeline can still take a beat when the output drains.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_vld || s2_adv;

    // Extra MSB of the zero-extended difference is the unsigned borrow.
    assign diff = {1'b0, s1_a} - {1'b0, s1_b};

    always_comb begin
        nxt_y   = diff[WIDTH-1:0];
        nxt_sat = 1'b0;
        case (s1_mode)
            2'b00: begin
                if (diff[WIDTH]) begin
                    nxt_y   = '0;
                    nxt_sat = 1'b1;
                end
            end
            2'b01: begin
                if ((s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1])) begin
                    nxt_y   = {s1_a[WIDTH-1], {(WIDTH-1){~s1_a[WIDTH-1]}}};
                    nxt_sat = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_mode <= '0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_mode <= mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            sat       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                y   <= nxt_y;
                sat <= nxt_sat;
            end
        end
    end

`ifdef SATSUB_STICKY_EN
    // A saturating transfer wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_sticky <= 1'b0;
        end else if (out_valid && out_ready && sat) begin
            sat_sticky <= 1'b1;
        end else if (sat_clr) begin
            sat_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_satsub_pipe.sv
// Scoreboard bench for satsub_pipe: expected {sat,y} queued at input acceptance, compared at output transfer.
module tb_satsub_pipe;

    localparam int W = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [1:0]    mode = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  y;
    logic          sat;
`ifdef SATSUB_STICKY_EN
    logic          sat_clr = 1'b0;
    logic          sat_sticky;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [W:0] exp_q[$];

    satsub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sat       (sat)
`ifdef SATSUB_STICKY_EN
        ,
        .sat_clr   (sat_clr),
        .sat_sticky(sat_sticky)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running, required finished");
        $fatal(1);
    end

    // Reference model built from integer arithmetic, returns {sat, y}.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic [1:0] mm);
        int ua, ub, sa, sb, r;
        logic [W:0] res;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (mm == 2'b00) begin
            if (ua < ub) res = {1'b1, 12'h000};
            else begin
                r = ua - ub;
                res = {1'b0, r[W-1:0]};
            end
        end else if (mm == 2'b01) begin
            r = sa - sb;
            if (r > 2047)       res = {1'b1, 12'h7FF};
            else if (r < -2048) res = {1'b1, 12'h800};
            else                res = {1'b0, r[W-1:0]};
        end else begin
            r = ua - ub + 4096;
            res = {1'b0, r[W-1:0]};
        end
        return res;
    endfunction

    // One clock cycle: drive, retire any output transfer against the queue, enqueue on acceptance.
    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [1:0] im, input logic ordy, input logic [W:0] e,
                        output logic acc);
        logic [W:0] got;
        logic [W:0] want;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        mode      = im;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            got = {sat, y};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat: got sat=%0b y=%03h, required no output", sat, y);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_err++;
                    $display("FAIL result: got sat=%0b y=%03h, required sat=%0b y=%03h",
                             got[W], got[W-1:0], want[W], want[W-1:0]);
                end
            end
        end
        acc = iv && in_ready;
        if (acc) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) step(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, sat, y} !== {1'b0, 1'b0, 12'h000}) begin
            n_err++;
            $display("FAIL reset_outputs: got out_valid=%0b sat=%0b y=%03h, required 0 0 000",
                     out_valid, sat, y);
        end
`ifdef SATSUB_STICKY_EN
        n_cmp++;
        if (sat_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL reset_sticky: got %0b, required 0", sat_sticky);
        end
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
    endtask

    // First edge after release must accept; result appears two cycles after acceptance.
    task automatic test_unsigned_latency();
        logic acc;
        step(1'b1, 12'h005, 12'h00A, 2'b00, 1'b1, {1'b1, 12'h000}, acc);
        n_cmp++;
        if (acc !== 1'b1) begin
            n_err++;
            $display("FAIL first_accept: got %0b, required 1", acc);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: got out_valid=%0b one cycle after accept, required 0", out_valid);
        end
        step(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL latency: got out_valid=%0b two cycles after accept, required 1", out_valid);
        end
        drain();
    endtask

    task automatic test_signed();
        logic acc;
        step(1'b1, 12'h800, 12'h001, 2'b01, 1'b1, {1'b1, 12'h800}, acc);
        step(1'b1, 12'h7FF, 12'hFFF, 2'b01, 1'b1, {1'b1, 12'h7FF}, acc);
        step(1'b1, 12'h003, 12'h005, 2'b01, 1'b1, {1'b0, 12'hFFE}, acc);
        step(1'b1, 12'h7FF, 12'h7FF, 2'b01, 1'b1, {1'b0, 12'h000}, acc);
        drain();
    endtask

    task automatic test_wrap();
        logic acc;
        step(1'b1, 12'h000, 12'h001, 2'b10, 1'b1, {1'b0, 12'hFFF}, acc);
        step(1'b1, 12'hFFF, 12'hFFF, 2'b00, 1'b1, {1'b0, 12'h000}, acc);
        step(1'b1, 12'h800, 12'h001, 2'b11, 1'b1, {1'b0, 12'h7FF}, acc);
        step(1'b1, 12'h00A, 12'h005, 2'b00, 1'b1, {1'b0, 12'h005}, acc);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va[8];
        logic [W-1:0] vb[8];
        logic [1:0]   vm[8];
        logic [W:0]   hold;
        logic         acc;
        int           i;
        int           c;
        for (int k = 0; k < 8; k++) begin
            va[k] = W'($urandom);
            vb[k] = W'($urandom);
            vm[k] = 2'(k);
        end
        hold = '0;
        i = 0;
        c = 0;
        while (i < 8 && c < 60) begin
            step(1'b1, va[i], vb[i], vm[i], (c >= 5), model(va[i], vb[i], vm[i]), acc);
            if (acc) i++;
            if (c == 1) hold = {sat, y};
            if (c >= 2 && c <= 4) begin
                n_cmp++;
                if (out_valid !== 1'b1 || {sat, y} !== hold) begin
                    n_err++;
                    $display("FAIL hold_stable: got out_valid=%0b sat=%0b y=%03h, required 1 %0b %03h",
                             out_valid, sat, y, hold[W], hold[W-1:0]);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (i != 2 || in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_accepts: got %0d accepted in_ready=%0b, required 2 and 0",
                             i, in_ready);
                end
            end
            c++;
        end
        n_cmp++;
        if (i != 8) begin
            n_err++;
            $display("FAIL b2b_accept: got %0d beats accepted, required 8", i);
        end
        drain();
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [1:0]   rm;
        logic         acc;
        int           i;
        int           c;
        i = 0;
        c = 0;
        ra = W'($urandom);
        rb = W'($urandom);
        rm = 2'($urandom);
        while (i < 40 && c < 400) begin
            step(($urandom_range(0, 3) != 0), ra, rb, rm, ($urandom_range(0, 9) < 7),
                 model(ra, rb, rm), acc);
            if (acc) begin
                i++;
                ra = W'($urandom);
                rb = W'($urandom);
                rm = 2'($urandom);
            end
            c++;
        end
        n_cmp++;
        if (i != 40) begin
            n_err++;
            $display("FAIL random_accept: got %0d beats accepted, required 40", i);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        logic acc;
        step(1'b1, 12'h010, 12'h001, 2'b00, 1'b0, model(12'h010, 12'h001, 2'b00), acc);
        step(1'b1, 12'h020, 12'h001, 2'b00, 1'b0, model(12'h020, 12'h001, 2'b00), acc);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midflight_reset: got out_valid=%0b during reset, required 0", out_valid);
        end
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL stale_result: got out_valid=%0b y=%03h after reset, required 0", out_valid, y);
            end
        end
        step(1'b1, 12'h123, 12'h023, 2'b00, 1'b1, {1'b0, 12'h100}, acc);
        drain();
    endtask

`ifdef SATSUB_STICKY_EN
    task automatic test_sticky();
        logic acc;
        step(1'b1, 12'h000, 12'h001, 2'b00, 1'b0, {1'b1, 12'h000}, acc);
        step(1'b1, 12'h001, 12'h002, 2'b00, 1'b0, {1'b1, 12'h000}, acc);
        step(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);
        n_cmp++;
        if (sat_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL sticky_set: got %0b, required 1", sat_sticky);
        end
        sat_clr = 1'b1;
        step(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);
        n_cmp++;
        if (sat_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL sticky_set_wins: got %0b, required 1", sat_sticky);
        end
        step(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);
        sat_clr = 1'b0;
        n_cmp++;
        if (sat_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL sticky_clear: got %0b, required 0", sat_sticky);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned_latency();
        test_signed();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_midflight();
`ifdef SATSUB_STICKY_EN
        test_sticky();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
